// File: rtl/arb_pkg.sv
// Shared widths, FSM state type and the round-robin search used by rr_arbiter_8.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // First set bit of ereq in the order ptr, ptr+1, ..., ptr+7 (3-bit wrap).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] ereq,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && ereq[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dec3to8_en.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module dec3to8_en
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  assign onehot = en ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter: level-held grants, a turnaround gap between
// owners, and an optional hold-time limit that preempts the current owner.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] cfg_mask,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam bit         LIMIT_EN  = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       hold_cnt;
  logic [N_REQ-1:0] ereq;

  assign ereq = req & ~cfg_mask;

  // NOTE: state and outputs are all updated with non-blocking assignments so
  // every term on the right-hand side is the value from before this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      preempt <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ereq != '0) begin
            state     <= GRANT;
            gnt_idx   <= rr_pick(ereq, ptr);
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        GRANT: begin
          // Release wins over the limit, so a simultaneous drop never pulses preempt.
          if (!ereq[gnt_idx]) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + IDX_W'(1);
          end else if (LIMIT_EN && hold_cnt == HOLD_LAST) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            preempt   <= 1'b1;
            ptr       <= gnt_idx + IDX_W'(1);
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dec3to8_en u_dec (
    .idx    (gnt_idx),
    .en     (gnt_valid),
    .onehot (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed and randomized bench for rr_arbiter_8 against a behavioural owner/pointer model.
module tb_rr_arbiter_8;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] cfg_mask;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int n_cmp = 0;
  int n_err = 0;

  rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .cfg_mask  (cfg_mask),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the resource, for how many cycles so far,
  // and where the next search starts.
  int  m_owner = -1;
  int  m_idx   = 0;
  int  m_ptr   = 0;
  int  m_cnt   = 0;
  bit  m_pre   = 0;
  bit  m_valid = 0;

  always @(posedge clk) begin
    logic [7:0] e;
    m_valid = 1;
    if (!rst_n) begin
      m_owner = -1; m_idx = 0; m_ptr = 0; m_cnt = 0; m_pre = 0;
    end else begin
      e     = req & ~cfg_mask;
      m_pre = 0;
      if (m_owner < 0) begin
        for (int k = 0; k < 8; k++) begin
          if (m_owner < 0 && e[(m_ptr + k) % 8]) begin
            m_owner = (m_ptr + k) % 8;
            m_idx   = m_owner;
            m_cnt   = 1;
          end
        end
      end else if (!e[m_owner]) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else if (MAX_HOLD != 0 && m_cnt == MAX_HOLD) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_pre   = 1;
      end else begin
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
      check("gnt_idx", 32'(gnt_idx), 32'(m_idx));
      check("preempt", 32'(preempt), 32'(m_pre));
      check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    end
  end

  // Advances at least one cycle, then waits (bounded) until a grant is visible.
  task automatic wait_grant(input string name);
    bit seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req = 8'hFF; cfg_mask = 8'h00;

    // Reset with all requests high
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h00);
    check("rst_valid", 32'(gnt_valid), 32'd0);
    check("rst_preempt", 32'(preempt), 32'd0);
    rst_n = 1'b1; req = 8'h01;
    @(negedge clk);
    check("first_gnt", 32'(gnt), 32'h01);
    check("first_idx", 32'(gnt_idx), 32'd0);

    // Rotation: each owner keeps its request for 3 cycles
    req = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) wait_grant("rot");
      check("rot_idx", 32'(gnt_idx), 32'(i));
      repeat (2) @(negedge clk);
      req[i] = 1'b0;
      @(negedge clk);
      check("rot_gap", 32'(gnt), 32'h00);
      req = (i == 7) ? 8'h00 : 8'hFF;
    end
    repeat (3) @(negedge clk);

    // Wrap: ptr=6 after idx5, then 0 and 1
    req = 8'h20;
    wait_grant("wrap5");
    check("wrap_idx5", 32'(gnt_idx), 32'd5);
    req = 8'h00;
    @(negedge clk);
    req = 8'h03;
    wait_grant("wrap0");
    check("wrap_idx0", 32'(gnt_idx), 32'd0);
    req = 8'h02;
    wait_grant("wrap1");
    check("wrap_idx1", 32'(gnt_idx), 32'd1);

    // Hold-time limit
    req = 8'h00;
    @(negedge clk);
    req = 8'h18;
    wait_grant("lim3");
    check("lim_idx3", 32'(gnt_idx), 32'd3);
    n = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (gnt_valid === 1'b1) n++;
      else break;
    end
    check("lim_len", 32'(n), 32'd4);
    check("lim_preempt", 32'(preempt), 32'd1);
    @(negedge clk);
    check("lim_preempt_clr", 32'(preempt), 32'd0);
    check("lim_next_gnt", 32'(gnt), 32'h10);

    // Release in the last allowed cycle is not a preemption
    req = 8'h08;
    wait_grant("lim3b");
    check("lim_idx3b", 32'(gnt_idx), 32'd3);
    repeat (3) @(negedge clk);
    req = 8'h00;
    @(negedge clk);
    check("rel_last_gnt", 32'(gnt), 32'h00);
    check("rel_last_preempt", 32'(preempt), 32'd0);

    // Masking removes the owner and blocks further grants
    req = 8'h04;
    wait_grant("mask2");
    check("mask_idx2", 32'(gnt_idx), 32'd2);
    cfg_mask = 8'h04;
    @(negedge clk);
    check("mask_gnt", 32'(gnt), 32'h00);
    check("mask_preempt", 32'(preempt), 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("mask_blocked", 32'(gnt_valid), 32'd0);
    end
    cfg_mask = 8'h00; req = 8'h00;
    @(negedge clk);

    // Mid-grant reset with ptr=6 beforehand
    req = 8'h20;
    wait_grant("mr5a");
    req = 8'h00;
    @(negedge clk);
    req = 8'h20;
    wait_grant("mr5b");
    rst_n = 1'b0; req = 8'hA0;
    @(negedge clk);
    check("mr_gnt", 32'(gnt), 32'h00);
    check("mr_valid", 32'(gnt_valid), 32'd0);
    check("mr_idx", 32'(gnt_idx), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_regrant", 32'(gnt), 32'h20);

    // Randomized traffic, including occasional masks and resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      if ($urandom_range(0, 31) == 0) cfg_mask = 8'($urandom) & 8'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
